// File: rtl/rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module  : rf_wb_arb
// Purpose : Register-file writeback arbiter between the pipeline (A) and a
//           one-entry held long-latency result (B), with optional B
//           starvation forcing (macro RF_WB_ARB_STARVE_EN).
// Revision: 1.0 - initial release
// ============================================================================
module rf_wb_arb #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        a_vld,
    input  logic [3:0]  a_addr,
    input  logic [15:0] a_data,
    output logic        a_rdy,
    input  logic        b_vld,
    input  logic [3:0]  b_addr,
    input  logic [15:0] b_data,
    output logic        b_rdy,
    input  logic        hlt,
    output logic        rf_we,
    output logic [3:0]  rf_dst_addr,
    output logic [15:0] rf_dst,
    output logic [15:0] pend_mask,
    output logic        idle
);

    generate
        if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
            $error("rf_wb_arb: STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    logic        r_held;
    logic [3:0]  r_held_addr;
    logic [15:0] r_held_data;
    logic        r_rf_we;
    logic [3:0]  r_rf_dst_addr;
    logic [15:0] r_rf_dst;

    logic w_force;
    logic w_grant_a;
    logic w_grant_b;
    logic w_b_accept;
    logic w_discard;

`ifdef RF_WB_ARB_STARVE_EN
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);
    logic [3:0] r_starve_cnt;

    assign w_force = r_held && (r_starve_cnt == c_starve_limit);
`else
    assign w_force = 1'b0;
`endif

    assign a_rdy      = ~hlt & ~w_force;
    assign b_rdy      = ~r_held & ~hlt;
    assign w_b_accept = b_vld & b_rdy;
    assign w_grant_a  = ~w_force & a_vld & ~hlt;
    assign w_grant_b  = w_force | (~w_grant_a & r_held);
    // A younger write to the same register makes the held B result stale.
    assign w_discard  = w_grant_a & r_held & (a_addr == r_held_addr) & (a_addr != 4'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_held        <= 1'b0;
            r_held_addr   <= 4'd0;
            r_held_data   <= 16'd0;
            r_rf_we       <= 1'b0;
            r_rf_dst_addr <= 4'd0;
            r_rf_dst      <= 16'd0;
        end else begin
            r_rf_we <= 1'b0;
            if (w_grant_a) begin
                r_rf_we       <= (a_addr != 4'd0);
                r_rf_dst_addr <= a_addr;
                r_rf_dst      <= a_data;
            end else if (w_grant_b) begin
                r_rf_we       <= (r_held_addr != 4'd0);
                r_rf_dst_addr <= r_held_addr;
                r_rf_dst      <= r_held_data;
            end

            // b_rdy is low while held, so accept and release never coincide.
            if (w_grant_b || w_discard) begin
                r_held <= 1'b0;
            end else if (w_b_accept) begin
                r_held      <= 1'b1;
                r_held_addr <= b_addr;
                r_held_data <= b_data;
            end
        end
    end

`ifdef RF_WB_ARB_STARVE_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (!r_held || w_grant_b || w_discard) begin
            r_starve_cnt <= 4'd0;
        end else if (r_starve_cnt != c_starve_limit) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
        end
    end
`endif

    assign rf_we       = r_rf_we;
    assign rf_dst_addr = r_rf_dst_addr;
    assign rf_dst      = r_rf_dst;
    assign pend_mask   = r_held ? (16'h0001 << r_held_addr) : 16'h0000;
    assign idle        = ~r_held & ~r_rf_we;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arb.sv
`default_nettype none
// ============================================================================
// Module  : tb_rf_wb_arb
// Purpose : Directed self-checking bench for rf_wb_arb.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rf_wb_arb;

    logic        clk;
    logic        rst;
    logic        a_vld;
    logic [3:0]  a_addr;
    logic [15:0] a_data;
    logic        a_rdy;
    logic        b_vld;
    logic [3:0]  b_addr;
    logic [15:0] b_data;
    logic        b_rdy;
    logic        hlt;
    logic        rf_we;
    logic [3:0]  rf_dst_addr;
    logic [15:0] rf_dst;
    logic [15:0] pend_mask;
    logic        idle;

    int r_tests;
    int r_fails;

    rf_wb_arb #(.STARVE_LIMIT(4)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .a_vld      (a_vld),
        .a_addr     (a_addr),
        .a_data     (a_data),
        .a_rdy      (a_rdy),
        .b_vld      (b_vld),
        .b_addr     (b_addr),
        .b_data     (b_data),
        .b_rdy      (b_rdy),
        .hlt        (hlt),
        .rf_we      (rf_we),
        .rf_dst_addr(rf_dst_addr),
        .rf_dst     (rf_dst),
        .pend_mask  (pend_mask),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance past the next rising edge; inputs are then driven and outputs sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_b(input logic [3:0] addr, input logic [15:0] data);
        b_vld  = 1'b1;
        b_addr = addr;
        b_data = data;
        #1;
        chk("load_b_rdy", 32'(b_rdy), 32'd1);
        tick();
        b_vld = 1'b0;
        #1;
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        rst = 1'b1; hlt = 1'b0;
        a_vld = 1'b0; a_addr = 4'd0; a_data = 16'd0;
        b_vld = 1'b0; b_addr = 4'd0; b_data = 16'd0;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Post-reset state
        chk("rst_a_rdy", 32'(a_rdy), 32'd1);
        chk("rst_b_rdy", 32'(b_rdy), 32'd1);
        chk("rst_pend", 32'(pend_mask), 32'h0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_we", 32'(rf_we), 32'd0);

        // A only
        a_vld = 1'b1; a_addr = 4'd3; a_data = 16'h1234;
        #1;
        chk("a_rdy", 32'(a_rdy), 32'd1);
        tick();
        a_vld = 1'b0;
        chk("a_we", 32'(rf_we), 32'd1);
        chk("a_addr", 32'(rf_dst_addr), 32'd3);
        chk("a_data", 32'(rf_dst), 32'h1234);
        tick();
        chk("a_we_off", 32'(rf_we), 32'd0);
        chk("a_addr_hold", 32'(rf_dst_addr), 32'd3);
        chk("a_data_hold", 32'(rf_dst), 32'h1234);

        // B behind idle A: two-cycle latency
        load_b(4'd5, 16'hBEEF);
        chk("b_pend", 32'(pend_mask), 32'h0020);
        chk("b_rdy_held", 32'(b_rdy), 32'd0);
        chk("b_idle_held", 32'(idle), 32'd0);
        chk("b_we_early", 32'(rf_we), 32'd0);
        tick();
        chk("b_we", 32'(rf_we), 32'd1);
        chk("b_addr", 32'(rf_dst_addr), 32'd5);
        chk("b_data", 32'(rf_dst), 32'hBEEF);
        chk("b_pend_clr", 32'(pend_mask), 32'h0);
        chk("b_rdy_again", 32'(b_rdy), 32'd1);
        tick();
        chk("b_idle", 32'(idle), 32'd1);

        // Starvation: B at 7 against a continuous A stream
        load_b(4'd7, 16'h7777);
`ifdef RF_WB_ARB_STARVE_EN
        for (int i = 0; i < 4; i++) begin
            a_vld = 1'b1; a_addr = 4'(i + 1); a_data = 16'(16'hA000 + i);
            #1;
            chk("stv_a_rdy", 32'(a_rdy), 32'd1);
            tick();
            chk("stv_a_addr", 32'(rf_dst_addr), 32'(i + 1));
            chk("stv_pend", 32'(pend_mask), 32'h0080);
        end
        a_addr = 4'd10; a_data = 16'hA00A;
        #1;
        chk("stv_force_rdy", 32'(a_rdy), 32'd0);
        tick();
        chk("stv_b_we", 32'(rf_we), 32'd1);
        chk("stv_b_addr", 32'(rf_dst_addr), 32'd7);
        chk("stv_b_data", 32'(rf_dst), 32'h7777);
        chk("stv_rdy_back", 32'(a_rdy), 32'd1);
        tick();
        a_vld = 1'b0;
        chk("stv_a_resume", 32'(rf_dst_addr), 32'd10);
        chk("stv_a_resume_d", 32'(rf_dst), 32'hA00A);
`else
        for (int i = 0; i < 6; i++) begin
            a_vld = 1'b1; a_addr = 4'(i + 1); a_data = 16'(16'hA000 + i);
            #1;
            chk("pri_a_rdy", 32'(a_rdy), 32'd1);
            tick();
            chk("pri_a_addr", 32'(rf_dst_addr), 32'(i + 1));
            chk("pri_pend", 32'(pend_mask), 32'h0080);
        end
        a_vld = 1'b0;
        tick();
        chk("pri_b_addr", 32'(rf_dst_addr), 32'd7);
        chk("pri_b_data", 32'(rf_dst), 32'h7777);
`endif
        tick();

        // Supersede: younger A to the held address wins
        load_b(4'd9, 16'h9999);
        a_vld = 1'b1; a_addr = 4'd9; a_data = 16'h0001;
        tick();
        a_vld = 1'b0;
        chk("sup_we", 32'(rf_we), 32'd1);
        chk("sup_addr", 32'(rf_dst_addr), 32'd9);
        chk("sup_data", 32'(rf_dst), 32'h0001);
        chk("sup_pend", 32'(pend_mask), 32'h0);
        tick();
        chk("sup_no_b_we", 32'(rf_we), 32'd0);
        chk("sup_data_keep", 32'(rf_dst), 32'h0001);
        chk("sup_idle", 32'(idle), 32'd1);

        // Address zero write is accepted and dropped
        a_vld = 1'b1; a_addr = 4'd0; a_data = 16'hFFFF;
        #1;
        chk("z_a_rdy", 32'(a_rdy), 32'd1);
        tick();
        a_vld = 1'b0;
        chk("z_we", 32'(rf_we), 32'd0);
        chk("z_idle", 32'(idle), 32'd1);

        // Halt: no acceptances, held B still drains
        load_b(4'd2, 16'h2222);
        hlt = 1'b1; a_vld = 1'b1; a_addr = 4'd6; a_data = 16'h6666;
        #1;
        chk("h_a_rdy", 32'(a_rdy), 32'd0);
        chk("h_b_rdy", 32'(b_rdy), 32'd0);
        tick();
        chk("h_b_we", 32'(rf_we), 32'd1);
        chk("h_b_addr", 32'(rf_dst_addr), 32'd2);
        tick();
        chk("h_no_a_we", 32'(rf_we), 32'd0);
        chk("h_idle", 32'(idle), 32'd1);
        hlt = 1'b0; a_vld = 1'b0;
        tick();

        // Reset mid-operation discards the held entry
        load_b(4'd4, 16'h4444);
        chk("r_pend_pre", 32'(pend_mask), 32'h0010);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("r_we", 32'(rf_we), 32'd0);
        chk("r_pend", 32'(pend_mask), 32'h0);
        chk("r_idle", 32'(idle), 32'd1);
        tick();
        chk("r_no_write", 32'(rf_we), 32'd0);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
